// File: rtl/async_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : async_mem_arbiter
// Description : Two-requester round-robin arbiter in front of a single-port
//               memory with synchronous read (one-cycle read latency).
//               One grant per cycle, ready depends combinationally on valid.
//               Optional feature macro ARMLEOCPU_MEM_ARB_CLEAR_EN: after
//               reset, zero the whole memory before accepting requests.
// Revision    : 1.0 - initial release
// ============================================================================
module async_mem_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // requester 0
  input  logic                  c0_valid,
  output logic                  c0_ready,
  input  logic                  c0_write,
  input  logic [ADDR_WIDTH-1:0] c0_addr,
  input  logic [DATA_WIDTH-1:0] c0_wdata,
  output logic                  c0_rvalid,
  output logic [DATA_WIDTH-1:0] c0_rdata,
  // requester 1
  input  logic                  c1_valid,
  output logic                  c1_ready,
  input  logic                  c1_write,
  input  logic [ADDR_WIDTH-1:0] c1_addr,
  input  logic [DATA_WIDTH-1:0] c1_wdata,
  output logic                  c1_rvalid,
  output logic [DATA_WIDTH-1:0] c1_rdata,
  // memory side
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  init_done
);

  logic                  r_init_done;
  logic                  r_prio;       // 0: requester 0 wins a tie
  logic                  r_rvalid0;
  logic                  r_rvalid1;
  logic                  w_run_state;  // memory ready for normal traffic
  logic                  w_init_wr;    // clear-sequence write this cycle
  logic [ADDR_WIDTH-1:0] w_init_addr;
  logic                  w_ok;
  logic                  w_gnt0;
  logic                  w_gnt1;
  logic                  w_gnt;
  logic                  w_wr;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;

`ifdef ARMLEOCPU_MEM_ARB_CLEAR_EN
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] C_LAST_ADDR = '1;
  localparam logic [ADDR_WIDTH-1:0] C_ONE       = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] w_cnt_nxt;

  // State and clear-address registers; reset restarts the clear at address 0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Walk addresses upward writing zero; leave INIT after the last one, no wrap
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_init_wr   = 1'b0;
    w_init_addr = '0;
    case (r_state)
      ST_INIT: begin
        w_init_wr   = 1'b1;
        w_init_addr = r_cnt;
        if (r_cnt == C_LAST_ADDR) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_cnt_nxt = r_cnt + C_ONE;
        end
      end
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  assign w_run_state = (r_state == ST_RUN);
`else
  assign w_init_wr   = 1'b0;
  assign w_init_addr = '0;
  assign w_run_state = 1'b1;
`endif

  // init_done follows the run state one cycle later, cleared by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_init_done <= 1'b0;
    end else begin
      r_init_done <= w_run_state;
    end
  end

  assign init_done = r_init_done & rst_n;

  // Round-robin grant: a sole requester always wins, a tie goes to r_prio
  always_comb begin
    w_ok    = rst_n & r_init_done;
    w_gnt0  = w_ok & c0_valid & (~c1_valid | ~r_prio);
    w_gnt1  = w_ok & c1_valid & (~c0_valid |  r_prio);
    w_gnt   = w_gnt0 | w_gnt1;
    w_wr    = w_gnt1 ? c1_write : c0_write;
    w_addr  = w_gnt1 ? c1_addr  : c0_addr;
    w_wdata = w_gnt1 ? c1_wdata : c0_wdata;
  end

  assign c0_ready = w_gnt0;
  assign c1_ready = w_gnt1;

  // Priority moves away from whoever was just granted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prio <= 1'b0;
    end else if (w_gnt0) begin
      r_prio <= 1'b1;
    end else if (w_gnt1) begin
      r_prio <= 1'b0;
    end
  end

  // Memory port drive: clear writes, granted writes, granted reads; else zero
  always_comb begin
    mem_write = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    mem_raddr = '0;
    if (rst_n && w_init_wr) begin
      mem_write = 1'b1;
      mem_waddr = w_init_addr;
    end else if (w_gnt && w_wr) begin
      mem_write = 1'b1;
      mem_waddr = w_addr;
      mem_wdata = w_wdata;
    end else if (w_gnt) begin
      mem_raddr = w_addr;
    end
  end

  // Remember which requester owns the read data returning next cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_rvalid0 <= w_gnt0 & ~c0_write;
      r_rvalid1 <= w_gnt1 & ~c1_write;
    end
  end

  // A reset arriving while data is in flight suppresses its delivery
  assign c0_rvalid = r_rvalid0 & rst_n;
  assign c1_rvalid = r_rvalid1 & rst_n;
  assign c0_rdata  = c0_rvalid ? mem_rdata : '0;
  assign c1_rdata  = c1_rvalid ? mem_rdata : '0;

endmodule
`default_nettype wire

// File: doc/async_mem_arbiter.md
ASYNC_MEM_ARBITER -- requirements
Module: async_mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, the memory address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, the memory data width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-005 The block SHALL have ports cN_valid, input, 1, request from requester N (N = 0, 1).
REQ-006 The block SHALL have ports cN_ready, output, 1, request accepted this cycle.
REQ-007 The block SHALL have ports cN_write, input, 1, 1 = write, 0 = read.
REQ-008 The block SHALL have ports cN_addr, input, ADDR_WIDTH, the request address.
REQ-009 The block SHALL have ports cN_wdata, input, DATA_WIDTH, the write data.
REQ-010 The block SHALL have ports cN_rvalid, output, 1, read data valid for requester N.
REQ-011 The block SHALL have ports cN_rdata, output, DATA_WIDTH, the read data.
REQ-012 The block SHALL have port mem_write, output, 1, the memory write enable.
REQ-013 The block SHALL have ports mem_waddr and mem_raddr, output, ADDR_WIDTH, the memory write and read addresses.
REQ-014 The block SHALL have port mem_wdata, output, DATA_WIDTH, the memory write data.
REQ-015 The block SHALL have port mem_rdata, input, DATA_WIDTH, the memory read data, valid one clock after mem_raddr is sampled.
REQ-016 The block SHALL have port init_done, output, 1, high when the block accepts requests.

Function
REQ-017 At most one request SHALL be granted per cycle; a grant is cN_ready=1 with cN_valid=1 in the same cycle (ready depends combinationally on valid).
REQ-018 A grant SHALL be issued only when init_done=1; with a single valid requester, that requester is granted.
REQ-019 With both requesters valid, the block SHALL grant the requester holding priority; priority then passes to the other requester (round-robin); a single-requester grant also passes priority away from the granted requester.
REQ-020 In a write-grant cycle, mem_write=1, mem_waddr=cN_addr and mem_wdata=cN_wdata; in all other cycles, mem_write=0.
REQ-021 In a read-grant cycle, mem_raddr=cN_addr; exactly one cycle later, cN_rvalid=1 and cN_rdata=mem_rdata for the granted requester only.
REQ-022 When no grant is issued, mem_waddr, mem_raddr and mem_wdata SHALL be driven to 0.
REQ-023 Back-to-back grants SHALL be sustained at 1 request per cycle, with no bubbles.
REQ-024 A read of address A granted the cycle after a write to A SHALL return the new data.
REQ-025 cN_rdata SHALL be 0 whenever cN_rvalid=0.

Reset
REQ-026 While rst_n=0, the block SHALL drive cN_ready=0, cN_rvalid=0 and mem_write=0, and SHALL give priority to requester 0.
REQ-027 Reset during an outstanding read SHALL drop that read; no rvalid is issued after reset.
REQ-028 Reset during the init sequence SHALL restart the sequence at address 0.

Configuration
REQ-029 With macro ARMLEOCPU_MEM_ARB_CLEAR_EN defined, after reset the block SHALL be in state INIT: it writes 0 to addresses 0 .. 2^ADDR_WIDTH-1, one per cycle, ascending, with init_done=0 and all cN_ready=0.
REQ-030 With the macro defined, the block SHALL go from INIT to RUN after the last address is written; init_done=1 from the following cycle, and the address counter does not wrap.
REQ-031 Without the macro, the block SHALL have only the RUN state, with init_done=1 in the first cycle after rst_n rises and no init writes.

Verification
REQ-032 Write and read on c0: a write to addr 5 of data 100, then a write to addr 6 of data 101, then a read of addr 5 -> c0_rvalid=1 with rdata=100 one cycle after the read grant; a read of addr 6 -> 101.
REQ-033 Contention: c0 and c1 both valid for 4 cycles after reset -> grants go c0, c1, c0, c1.
REQ-034 Read-after-write: a c1 write to addr 7 of 0xDEAD, then next cycle a c0 read of addr 7 -> c0_rdata=0xDEAD and c1_rvalid stays 0.
REQ-035 Reset mid-read: rst_n=0 in the cycle after a c0 read grant -> c0_rvalid stays 0 and priority returns to c0.
REQ-036 With ARMLEOCPU_MEM_ARB_CLEAR_EN, ADDR_WIDTH=8: init_done rises 257 cycles after reset release with no grants before that; a subsequent read of addr 200 -> 0.
